adder_share_arb: RTL and testbench
==================================

// Module: adder_share_arb
// PURPOSE
//   Round-robin scheduler that shares one N-bit adder among NREQ requesters carrying packets of flits.
//   A requester holds the adder for a whole packet (burst locked until req_last) so flit streams stay contiguous.
//   The adder result sits in a one-entry output register with valid/ready backpressure.
//   Sits between flit-injection sources and the energy-characterised adder datapath.
// PARAMETERS
//   N     22  operand/sum width in bits
//   NREQ  4   number of requesters (2..16)
//   IDW   2   width of rsp_id; must be >= clog2(NREQ)
// PORTS
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   req_valid  in   NREQ      per-requester flit valid
//   req_last   in   NREQ      per-requester last flit of packet
//   req_a      in   NREQ*N    operand A, requester i at [i*N +: N]
//   req_b      in   NREQ*N    operand B, same packing as req_a
//   req_ready  out  NREQ      one-hot accept; the flit transfers when valid&ready
//   rsp_valid  out  1         result register holds data
//   rsp_ready  in   1         consumer accepts the result
//   rsp_sum    out  N         (a+b) mod 2^N, carry discarded
//   rsp_id     out  IDW       index of the requester that produced rsp_sum
//   rsp_last   out  1         copy of req_last for this flit
// BEHAVIOUR
//   Reset: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_last=0, state=IDLE, rr pointer=0.
//   out_free = !rsp_valid | rsp_ready. No requester is granted while out_free=0.
//   FSM IDLE: if out_free and any req_valid, grant the first valid requester at or after the rr pointer (wrapping).
//     On accept with req_last=0 -> LOCKED(owner=g). With req_last=1, stay in IDLE.
//     Either way the rr pointer = g+1 mod NREQ.
//   FSM LOCKED: only the owner may be granted (req_ready[owner]=out_free & req_valid[owner]). Other requests are ignored.
//     Gaps (owner valid=0) keep the lock. Accept with req_last=1 -> IDLE.
//   req_ready is combinational from state, pointer, req_valid and out_free. It is never asserted to a requester with valid=0.
//   Latency: a flit accepted on edge k appears on rsp_* after edge k (1 cycle). Throughput is 1 flit/cycle with rsp_ready=1.
//   Result register: loads on accept. Otherwise rsp_valid clears when rsp_ready=1 and holds when rsp_ready=0. Simultaneous drain+load is allowed.
//   Operand overflow wraps: all-ones + 1 -> 0. The carry is not reported.
//   Reset mid-packet: lock dropped, pending result lost, pointer=0. Requesters must restart packets.
//   NREQ=1: the arbiter degenerates to pass-through with lock. The FSM is still present.
// CONFIGURATION
//   ACTIVITY_CNT_EN defined: adds output act_ops[31:0] and output act_toggles[31:0], both reset 0 and saturating at 2^32-1.
//     act_ops counts accepted flits.
//     act_toggles adds popcount({a,b} ^ previous accepted {a,b}); the previous value resets to 0.
//   ACTIVITY_CNT_EN undefined: those ports and their logic are absent. Other behaviour is identical.
// STRUCTURE
//   Package adder_arb_pkg: state typedef (IDLE=1'b0, LOCKED=1'b1), ACT_CNT_W=32 and a popcount function.
//   Sub-module rr_arbiter (NREQ): inputs req, ptr; output one-hot gnt with wrap-around priority. Purely combinational.
//   Top level: FSM, owner/pointer regs, operand mux, adder, result register, optional counters.
// TESTING
//   1. Reset: assert rst_n=0 mid-traffic -> all outputs 0 at once. After release the first grant goes to req0 when all are valid.
//   2. Single packet: req1 sends 20 flits with a=3FFFFF, b=000001, rsp_ready=1.
//      -> 20 rsp with sum=000000, id=1, last only on flit 20, one per cycle.
//   3. Lock: req0 and req2 valid; req0 packet of 4 flits with a valid gap after flit 2.
//      -> req2 gets no grant until req0 last is accepted. Then req2 is granted on the next cycle.
//   4. Round-robin: all 4 requesters send 1-flit packets continuously -> rsp_id sequence 0,1,2,3,0,1...
//   5. Backpressure: hold rsp_ready=0 for 5 cycles with req3 valid.
//      -> rsp_* stable and req_ready=0. On release the held flit drains, then the next loads in the same cycle.
//   6. ACTIVITY_CNT_EN: req0 sends a=000000,b=000000 then a=3FFFFF,b=3FFFFF -> act_ops=2, act_toggles=44.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg
//   Shared types and helpers for the shared-adder round-robin scheduler.
//   state_t   : scheduler FSM encoding (IDLE / LOCKED)
//   ACT_CNT_W : width of the optional activity counters
//   popcount  : number of set bits in a zero-extended vector of up to POP_W bits
package adder_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int ACT_CNT_W = 32;
  localparam int POP_W     = 128;

  function automatic logic [ACT_CNT_W-1:0] popcount(input logic [POP_W-1:0] v);
    logic [ACT_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_W; i++) begin
      c = c + ACT_CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: grants the first asserted request
//   at or after ptr, wrapping past NREQ-1 back to 0.
//   req : request vector (NREQ)
//   ptr : highest-priority index this cycle (must be < NREQ)
//   gnt : one-hot grant, all zeros when no request is asserted
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr) + off) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb
//   Shares one N-bit adder among NREQ flit requesters. A requester keeps the
//   adder for a whole packet (locked until its req_last flit is accepted);
//   between packets the next owner is chosen round-robin. Each sum lands in a
//   one-entry result register drained with valid/ready.
//
//   Handshake semantics (both sides): a transfer happens on a rising clk edge
//   where valid && ready. req_ready is one-hot, never asserted to a requester
//   whose req_valid is low, and is low while the result register cannot take
//   a new value (rsp_valid && !rsp_ready). rsp_* hold steady while
//   rsp_valid && !rsp_ready.
//
//   Ports
//     clk, rst_n          clock (rising) / asynchronous active-low reset
//     req_valid/req_last  per-requester flit valid / last-of-packet
//     req_a, req_b        operands, requester i at [i*N +: N]
//     req_ready           one-hot accept
//     rsp_valid/rsp_ready result handshake
//     rsp_sum             (a+b) mod 2^N
//     rsp_id, rsp_last    producing requester, copy of its req_last
//     act_ops, act_toggles  activity counters (only with ACTIVITY_CNT_EN)
//     dbg_state           current scheduler state
//
//   Build option: define ACTIVITY_CNT_EN to add the act_ops / act_toggles
//   saturating counters.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int N    = 22,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*N-1:0]    req_a,
  input  logic [NREQ*N-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_last,
`ifdef ACTIVITY_CNT_EN
  output logic [ACT_CNT_W-1:0] act_ops,
  output logic [ACT_CNT_W-1:0] act_toggles,
`endif
  output state_t               dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   next_ptr;
  logic [NREQ-1:0] arb_gnt;
  logic            out_free;
  logic            accept;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic [N-1:0]    sum;
  logic            last_sel;

  assign dbg_state = state;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // The result register can take a new flit when empty or draining this cycle.
  assign out_free = !rsp_valid || rsp_ready;

  // Gating with rst_n keeps req_ready low for the whole reset, not just after it.
  always_comb begin
    req_ready = '0;
    if (rst_n && out_free) begin
      if (state == IDLE) begin
        req_ready = arb_gnt;
      end else begin
        req_ready[owner] = req_valid[owner];
      end
    end
  end

  assign accept = |req_ready;

  // Operand mux driven straight from the one-hot grant.
  always_comb begin
    sel      = '0;
    a_sel    = '0;
    b_sel    = '0;
    last_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel      = PW'(i);
        a_sel    = req_a[i*N +: N];
        b_sel    = req_b[i*N +: N];
        last_sel = req_last[i];
      end
    end
  end

  // Carry out is intentionally dropped.
  assign sum      = a_sel + b_sel;
  assign next_ptr = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
    end else begin
      // Result register: a load wins over (and may coincide with) a drain.
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= sum;
        rsp_id    <= IDW'(sel);
        rsp_last  <= last_sel;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            ptr <= next_ptr;
            if (!last_sel) begin
              state <= LOCKED;
              owner <= sel;
            end
          end
        end
        LOCKED: begin
          // Only the owner can be accepted here; gaps keep the lock.
          if (accept && last_sel) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACTIVITY_CNT_EN
  logic [2*N-1:0]       prev_ab;
  logic [ACT_CNT_W-1:0] flips;
  logic [ACT_CNT_W:0]   tog_sum;

  assign flips   = popcount(POP_W'({a_sel, b_sel} ^ prev_ab));
  assign tog_sum = {1'b0, act_toggles} + {1'b0, flips};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_ops     <= '0;
      act_toggles <= '0;
      prev_ab     <= '0;
    end else if (accept) begin
      if (act_ops != '1) begin
        act_ops <= act_ops + 1'b1;
      end
      act_toggles <= tog_sum[ACT_CNT_W] ? '1 : tog_sum[ACT_CNT_W-1:0];
      prev_ab     <= {a_sel, b_sel};
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb
//   Directed bench for adder_share_arb (N=22, NREQ=4, IDW=2): reset, long
//   packet with overflow, lock with gap, round-robin, backpressure and, when
//   ACTIVITY_CNT_EN is defined, the activity counters.
module tb_adder_share_arb;
  import adder_arb_pkg::*;

  localparam int N    = 22;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int EW   = IDW + 1 + N;

  // ---------------- clock / reset / DUT ----------------
  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*N-1:0]  req_a;
  logic [NREQ*N-1:0]  req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [N-1:0]       rsp_sum;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_last;
  state_t             dbg_state;
`ifdef ACTIVITY_CNT_EN
  logic [31:0]        act_ops;
  logic [31:0]        act_toggles;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_share_arb #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_sum     (rsp_sum),
    .rsp_id      (rsp_id),
    .rsp_last    (rsp_last),
`ifdef ACTIVITY_CNT_EN
    .act_ops     (act_ops),
    .act_toggles (act_toggles),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] rsp_word(input logic [IDW-1:0] id, input logic last,
                                             input logic [N-1:0] s);
    return {id, last, s};
  endfunction

  // Scoreboard: every result transfer must match the head of exp_q.
  always @(negedge clk) begin
    if (mon_en && rst_n && rsp_valid && rsp_ready) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("rsp_word", 64'({rsp_id, rsp_last, rsp_sum}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; applies valid/last, checks req_ready mid-cycle and
  // returns at the next posedge+1.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                       input logic [NREQ-1:0] exp_rdy, input string tag);
    req_valid = v;
    req_last  = l;
    @(negedge clk);
    check(tag, 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. Reset mid-traffic
    for (int i = 0; i < NREQ; i++) set_op(i, N'(i + 1), 22'h10);
    req_valid = '1;
    req_last  = '1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("t1_rsp_valid", 64'(rsp_valid), 64'h0);
    check("t1_rsp_sum", 64'(rsp_sum), 64'h0);
    check("t1_rsp_id", 64'(rsp_id), 64'h0);
    check("t1_rsp_last", 64'(rsp_last), 64'h0);
    check("t1_req_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_first_grant", 64'(req_ready), 64'h1);
    req_valid = '0;
    @(posedge clk);
    #1;
    check("t1_no_rsp", 64'(rsp_valid), 64'h0);
    exp_q.delete();
    mon_en = 1'b1;

    // 2. req1 packet of 20 flits, all-ones + 1 wraps to 0
    set_op(1, 22'h3FFFFF, 22'h000001);
    for (int f = 1; f <= 20; f++) exp_q.push_back(rsp_word(2'd1, f == 20, 22'h0));
    for (int f = 1; f <= 20; f++) begin
      cycle(4'b0010, (f == 20) ? 4'b0010 : 4'b0000, 4'b0010, "t2_ready");
    end
    req_valid = '0;
    wait_drain(1, "t2_one_per_cycle");

    // 3. Lock: req0 4-flit packet with a gap, req2 waits
    set_op(2, 22'h2AAAAA, 22'h155555);
    for (int f = 1; f <= 4; f++) exp_q.push_back(rsp_word(2'd0, f == 4, N'(f * 256 + 17)));
    exp_q.push_back(rsp_word(2'd2, 1'b1, 22'h3FFFFF));
    set_op(0, 22'h100, 22'h11);
    cycle(4'b0001, 4'b0100, 4'b0001, "t3_f1");
    set_op(0, 22'h200, 22'h11);
    cycle(4'b0101, 4'b0100, 4'b0001, "t3_f2");
    cycle(4'b0100, 4'b0100, 4'b0000, "t3_gap");
    check("t3_locked", 64'(dbg_state), 64'(LOCKED));
    set_op(0, 22'h300, 22'h11);
    cycle(4'b0101, 4'b0100, 4'b0001, "t3_f3");
    set_op(0, 22'h400, 22'h11);
    cycle(4'b0101, 4'b0101, 4'b0001, "t3_f4");
    cycle(4'b0100, 4'b0100, 4'b0100, "t3_req2");
    req_valid = '0;
    wait_drain(4, "t3_drain");

    // 4. Round-robin: req3 alone moves the pointer to 0, then all contend
    set_op(3, 22'h3, 22'h0);
    exp_q.push_back(rsp_word(2'd3, 1'b1, 22'h3));
    cycle(4'b1000, 4'b1111, 4'b1000, "t4_pre");
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, N'(i), N'(16 * c));
      exp_q.push_back(rsp_word(IDW'(c % 4), 1'b1, N'((c % 4) + 16 * c)));
      cycle(4'b1111, 4'b1111, NREQ'(1 << (c % 4)), "t4_rr");
    end
    req_valid = '0;
    wait_drain(4, "t4_drain");

    // 5. Backpressure on req3
    set_op(3, 22'h123456, 22'h111111);
    exp_q.push_back(rsp_word(2'd3, 1'b1, 22'h234567));
    cycle(4'b1000, 4'b1111, 4'b1000, "t5_x");
    rsp_ready = 1'b0;
    set_op(3, 22'h000100, 22'h000023);
    exp_q.push_back(rsp_word(2'd3, 1'b1, 22'h000123));
    for (int c = 0; c < 5; c++) begin
      cycle(4'b1000, 4'b1111, 4'b0000, "t5_hold_ready");
      check("t5_hold_valid", 64'(rsp_valid), 64'h1);
      check("t5_hold_sum", 64'(rsp_sum), 64'h234567);
    end
    rsp_ready = 1'b1;
    cycle(4'b1000, 4'b1111, 4'b1000, "t5_release");
    check("t5_next_valid", 64'(rsp_valid), 64'h1);
    check("t5_next_sum", 64'(rsp_sum), 64'h000123);
    req_valid = '0;
    wait_drain(3, "t5_drain");

`ifdef ACTIVITY_CNT_EN
    // 6. Activity counters
    rst_n = 1'b0;
    #1;
    check("t6_rst_ops", 64'(act_ops), 64'h0);
    check("t6_rst_tog", 64'(act_toggles), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_op(0, 22'h0, 22'h0);
    exp_q.push_back(rsp_word(2'd0, 1'b1, 22'h0));
    cycle(4'b0001, 4'b0001, 4'b0001, "t6_f1");
    set_op(0, 22'h3FFFFF, 22'h3FFFFF);
    exp_q.push_back(rsp_word(2'd0, 1'b1, 22'h3FFFFE));
    cycle(4'b0001, 4'b0001, 4'b0001, "t6_f2");
    req_valid = '0;
    check("t6_act_ops", 64'(act_ops), 64'd2);
    check("t6_act_toggles", 64'(act_toggles), 64'd44);
    wait_drain(3, "t6_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
